// File: rtl/jk_reg_bank.sv
// jk_reg_bank
//   A bank of WIDTH JK flip-flops that share one clock and one synchronous
//   reset. Besides plain per-bit JK operation the bank offers parallel load,
//   up/down counting and serial shifting. Every mode is implemented by
//   steering the J/K inputs of the same JK cells, so there is only one
//   next-state equation for the whole bank.
//
// Parameters
//   WIDTH      number of JK cells (bits in q)
//   RESET_VAL  value loaded into q by reset
//
// Ports
//   clk    in   1      rising-edge clock
//   reset  in   1      synchronous, active-high reset
//   en     in   1      1 = update on this edge, 0 = hold all state
//   mode   in   2      00 JK, 01 LOAD, 10 COUNT, 11 SHIFT
//   j      in   WIDTH  per-bit J (JK mode); j[0] is the serial input (SHIFT)
//   k      in   WIDTH  per-bit K (JK mode)
//   d      in   WIDTH  parallel load data (LOAD mode)
//   up     in   1      count direction: 1 up, 0 down
//   q      out  WIDTH  register state
//   qn     out  WIDTH  ~q, combinational
//   tc     out  1      terminal count decode of the current q, combinational
//   chg    out  WIDTH  registered per-bit change flags for the last edge

module jk_reg_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc,
  output logic [WIDTH-1:0] chg
);

  typedef enum logic [1:0] {
    MODE_JK    = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_COUNT = 2'b10,
    MODE_SHIFT = 2'b11
  } mode_e;

  logic [WIDTH-1:0] j_eff;
  logic [WIDTH-1:0] k_eff;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] shift_val;
  logic [WIDTH-1:0] q_next;

  // Every mode is mapped onto the J/K inputs of the cells.
  // LOAD and SHIFT drive J=v, K=~v so each cell is forced to v.
  // COUNT drives J=K=1 on bits whose lower bits are all 1 (up) or all 0
  // (down): a ripple toggle chain in which bit 0 always toggles.
  always_comb begin
    logic run;
    j_eff     = '0;
    k_eff     = '0;
    toggle    = '0;
    shift_val = '0;
    run       = 1'b1;

    for (int i = 0; i < WIDTH; i++) begin
      toggle[i] = run;
      run       = run & (up ? q[i] : ~q[i]);
    end

    // Written as a loop so that WIDTH==1 collapses to q <= j[0].
    shift_val[0] = j[0];
    for (int i = 1; i < WIDTH; i++) begin
      shift_val[i] = q[i-1];
    end

    case (mode_e'(mode))
      MODE_JK: begin
        j_eff = j;
        k_eff = k;
      end
      MODE_LOAD: begin
        j_eff = d;
        k_eff = ~d;
      end
      MODE_COUNT: begin
        j_eff = toggle;
        k_eff = toggle;
      end
      MODE_SHIFT: begin
        j_eff = shift_val;
        k_eff = ~shift_val;
      end
    endcase

    // Characteristic JK equation: set on J, keep unless K.
    q_next = (j_eff & ~q) | (~k_eff & q);
  end

  // State register: reset beats enable, enable beats mode.
  // chg is cleared whenever the bank does not take a new value.
  always_ff @(posedge clk) begin
    if (reset) begin
      q   <= RESET_VAL;
      chg <= '0;
    end else if (!en) begin
      chg <= '0;
    end else begin
      q   <= q_next;
      chg <= q_next ^ q;
    end
  end

  assign qn = ~q;

  // Decode of the current value, i.e. the edge about to wrap.
  assign tc = (mode == MODE_COUNT) & (up ? (&q) : (~|q));

endmodule
